// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA raster timing source and its neighbours
// (pixel renderer on one side, DE2-115 video DAC on the other).
interface vga_timing_gen_if;
  logic       i_clk_en;
  logic [9:0] o_x_cord;
  logic [9:0] o_y_cord;
  logic [7:0] i_VGA_R;
  logic [7:0] i_VGA_G;
  logic [7:0] i_VGA_B;
  logic [7:0] o_VGA_R;
  logic [7:0] o_VGA_G;
  logic [7:0] o_VGA_B;
  logic       o_VGA_HS;
  logic       o_VGA_VS;
  logic       o_VGA_BLANK_N;
  logic       o_VGA_SYNC_N;
  logic       o_frame_start;
  logic       o_vblank;

  // Timing generator side.
  modport master (
    input  i_clk_en, i_VGA_R, i_VGA_G, i_VGA_B,
    output o_x_cord, o_y_cord, o_VGA_R, o_VGA_G, o_VGA_B,
    output o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N,
    output o_frame_start, o_vblank
  );

  // Renderer / DAC / game-logic side.
  modport slave (
    output i_clk_en, i_VGA_R, i_VGA_G, i_VGA_B,
    input  o_x_cord, o_y_cord, o_VGA_R, o_VGA_G, o_VGA_B,
    input  o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N,
    input  o_frame_start, o_vblank
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source. Sweeps the pixel/line counters, hands coordinates
// to the renderer, realigns the sync/blank qualifiers with the renderer's
// RGB after PIX_LAT enabled cycles, and registers everything toward the DAC
// so every pin sees the same PIX_LAT+1 cycle coordinate-to-pin latency.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Qualifiers that travel alongside the renderer's pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } tap_t;

  // Idle value: blanked with both syncs deasserted, so a restart never
  // emits a stray partial sync pulse.
  localparam tap_t TAP_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active_now;
  logic       hs_now;
  logic       vs_now;
  tap_t       tap_now;
  tap_t       tap_dly;
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic [7:0] b_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_n_q;

  // Raster counters: pixel counter every enabled cycle, line counter on pixel wrap.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (vga.i_clk_en) begin
      if (h_cnt == H_LAST_C) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST_C) v_cnt <= '0;
        else                   v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign active_now = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_now     = !((h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C));
  assign vs_now     = !((v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C));
  assign tap_now    = '{active: active_now, hs: hs_now, vs: vs_now};

  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign tap_dly = tap_now;
    end else begin : g_dly
      tap_t line_q [PIX_LAT];

      // Delay line matching the renderer latency, advancing only on enabled cycles.
      // NOTE: this small delay line is reset on purpose: its contents drive sync pins straight after reset, unlike data-only storage which could skip reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < PIX_LAT; i++) line_q[i] <= TAP_IDLE;
        end else if (vga.i_clk_en) begin
          line_q[0] <= tap_now;
          for (int i = 1; i < PIX_LAT; i++) line_q[i] <= line_q[i-1];
        end
      end

      assign tap_dly = line_q[PIX_LAT-1];
    end
  endgenerate

  // Output register toward the DAC; colour is forced black outside the active area.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (vga.i_clk_en) begin
      r_q       <= tap_dly.active ? vga.i_VGA_R : 8'd0;
      g_q       <= tap_dly.active ? vga.i_VGA_G : 8'd0;
      b_q       <= tap_dly.active ? vga.i_VGA_B : 8'd0;
      hs_q      <= tap_dly.hs;
      vs_q      <= tap_dly.vs;
      blank_n_q <= tap_dly.active;
    end
  end

  assign vga.o_x_cord      = active_now ? h_cnt : 10'd0;
  assign vga.o_y_cord      = active_now ? v_cnt : 10'd0;
  assign vga.o_VGA_R       = r_q;
  assign vga.o_VGA_G       = g_q;
  assign vga.o_VGA_B       = b_q;
  assign vga.o_VGA_HS      = hs_q;
  assign vga.o_VGA_VS      = vs_q;
  assign vga.o_VGA_BLANK_N = blank_n_q;
  assign vga.o_VGA_SYNC_N  = 1'b0;
  assign vga.o_frame_start = vga.i_clk_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign vga.o_vblank      = (v_cnt >= V_ACT_C);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock, reset and pixel
// enable: "a" uses the standard 640x480 geometry with a zero-latency
// renderer, "b" a tiny 25x17 raster with a two-cycle renderer so whole
// frames fit in a short run. Expected pin values come from pixel arithmetic
// on the number of enabled cycles since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;
    logic       vblank;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m = 0;           // enabled cycles since the last reset edge

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen #(.PIX_LAT(0)) dut_a (.clk(clk), .rst_n(rst_n), .vga(if_a));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIX_LAT(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vga(if_b));

  always #5 clk = ~clk;

  // Renderer for "a": colour is a pure function of the coordinate.
  assign if_a.i_clk_en = clk_en;
  assign if_a.i_VGA_R  = if_a.o_x_cord[7:0];
  assign if_a.i_VGA_G  = if_a.o_y_cord[7:0];
  assign if_a.i_VGA_B  = 8'hA5;

  // Renderer for "b": same colour function, two enabled cycles late.
  logic [23:0] rend1 = '0;
  logic [23:0] rend2 = '0;
  always @(posedge clk) begin
    if (clk_en) begin
      rend1 <= {if_b.o_x_cord[7:0], if_b.o_y_cord[7:0], 8'hA5};
      rend2 <= rend1;
    end
  end
  assign if_b.i_clk_en = clk_en;
  assign if_b.i_VGA_R  = rend2[23:16];
  assign if_b.i_VGA_G  = rend2[15:8];
  assign if_b.i_VGA_B  = rend2[7:0];

  always @(posedge clk) begin
    if (!rst_n)      m <= 0;
    else if (clk_en) m <= m + 1;
  end

  // Expected pins after mm enabled cycles: coordinate side shows pixel mm,
  // DAC side shows pixel mm-1-lat (idle values before that exists).
  function automatic obs_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                 input int lat, input int mm, input logic en);
    obs_t e;
    int   htot, tot, p, h, v, q, hq, vq;
    logic act;
    htot = ha + hf + hsw + hb;
    tot  = htot * (va + vf + vsw + vb);
    p = mm % tot;
    h = p % htot;
    v = p / htot;
    act = (h < ha) && (v < va);
    e.x           = act ? 10'(h) : 10'd0;
    e.y           = act ? 10'(v) : 10'd0;
    e.frame_start = en && (p == 0);
    e.vblank      = (v >= va);
    e.sync_n      = 1'b0;
    q = mm - 1 - lat;
    if (q < 0) begin
      e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
      e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0;
    end else begin
      p  = q % tot;
      hq = p % htot;
      vq = p / htot;
      act = (hq < ha) && (vq < va);
      e.blank_n = act;
      e.hs = !((hq >= ha + hf) && (hq < ha + hf + hsw));
      e.vs = !((vq >= va + vf) && (vq < va + vf + vsw));
      e.r  = act ? 8'(hq) : 8'd0;
      e.g  = act ? 8'(vq) : 8'd0;
      e.b  = act ? 8'hA5 : 8'd0;
    end
    return e;
  endfunction

  function automatic obs_t exp_a();
    return model(640, 16, 96, 48, 480, 10, 2, 33, 0, m, clk_en);
  endfunction

  function automatic obs_t exp_b();
    return model(16, 2, 4, 3, 10, 2, 2, 3, 2, m, clk_en);
  endfunction

  function automatic obs_t obs_a();
    return '{x: if_a.o_x_cord, y: if_a.o_y_cord, r: if_a.o_VGA_R, g: if_a.o_VGA_G,
             b: if_a.o_VGA_B, hs: if_a.o_VGA_HS, vs: if_a.o_VGA_VS,
             blank_n: if_a.o_VGA_BLANK_N, sync_n: if_a.o_VGA_SYNC_N,
             frame_start: if_a.o_frame_start, vblank: if_a.o_vblank};
  endfunction

  function automatic obs_t obs_b();
    return '{x: if_b.o_x_cord, y: if_b.o_y_cord, r: if_b.o_VGA_R, g: if_b.o_VGA_G,
             b: if_b.o_VGA_B, hs: if_b.o_VGA_HS, vs: if_b.o_VGA_VS,
             blank_n: if_b.o_VGA_BLANK_N, sync_n: if_b.o_VGA_SYNC_N,
             frame_start: if_b.o_frame_start, vblank: if_b.o_vblank};
  endfunction

  // One clock: inputs change just after the edge, outputs are sampled on the falling edge.
  task automatic tick(input logic en, input logic rst);
    @(posedge clk);
    #1;
    clk_en = en;
    rst_n  = rst;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    obs_t got, want;
    for (int k = 0; k < 6; k++) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      got = obs_a(); want = exp_a(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_a k=%0d got=%h want=%h", k, got, want);
      end
      got = obs_b(); want = exp_b(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_b k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_line_timing();
    obs_t got, want;
    int   fall0 = -1, fall1 = -1, low_cnt = 0, last_fs = -1;
    int   nz_a = 0, nz_b = 0, vb_b = 0;
    logic prev_hs = 1'b1;
    apply_reset();
    for (int k = 0; k < 2500; k++) begin
      tick(1'b1, 1'b1);
      got = obs_a(); want = exp_a(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL line_a m=%0d got=%h want=%h", m, got, want);
      end
      got = obs_b(); want = exp_b(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL line_b m=%0d got=%h want=%h", m, got, want);
      end
      if (k == 0) begin
        n_checks++;
        if (if_a.o_frame_start !== 1'b1 || if_b.o_frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL first_frame_start got a=%b b=%b want 1", if_a.o_frame_start, if_b.o_frame_start);
        end
      end
      if (prev_hs && !if_a.o_VGA_HS) begin
        if (fall0 < 0) fall0 = m;
        else if (fall1 < 0) fall1 = m;
      end
      prev_hs = if_a.o_VGA_HS;
      if (!if_a.o_VGA_HS && m < 1200) low_cnt++;
      if (if_b.o_frame_start) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (m - last_fs != 425) begin
            n_fail++; $display("FAIL frame_period_b got=%0d want=425", m - last_fs);
          end
        end
        last_fs = m;
      end
      if (m >= 1 && m < 801 && (|{if_a.o_VGA_R, if_a.o_VGA_G, if_a.o_VGA_B})) nz_a++;
      if (m >= 500 && m < 925 && (|{if_b.o_VGA_R, if_b.o_VGA_G, if_b.o_VGA_B})) nz_b++;
      if (m >= 500 && m < 925 && if_b.o_vblank) vb_b++;
    end
    n_checks++;
    if (fall0 != 657) begin
      n_fail++; $display("FAIL hs_fall got=%0d want=657", fall0);
    end
    n_checks++;
    if (fall1 - fall0 != 800) begin
      n_fail++; $display("FAIL hs_line_period got=%0d want=800", fall1 - fall0);
    end
    n_checks++;
    if (low_cnt != 96) begin
      n_fail++; $display("FAIL hs_width got=%0d want=96", low_cnt);
    end
    n_checks++;
    if (nz_a != 640) begin
      n_fail++; $display("FAIL lit_pixels_a got=%0d want=640", nz_a);
    end
    n_checks++;
    if (nz_b != 160) begin
      n_fail++; $display("FAIL lit_pixels_b got=%0d want=160", nz_b);
    end
    n_checks++;
    if (vb_b != 175) begin
      n_fail++; $display("FAIL vblank_b got=%0d want=175", vb_b);
    end
  endtask

  task automatic test_clk_en_toggle();
    obs_t got, want;
    int   last_fs = -1, fs_a_cnt = 0, vs_low = 0;
    logic prev_fs = 1'b0;
    apply_reset();
    for (int k = 0; k < 1800; k++) begin
      tick(1'(k % 2 == 0), 1'b1);
      got = obs_a(); want = exp_a(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL toggle_a k=%0d got=%h want=%h", k, got, want);
      end
      got = obs_b(); want = exp_b(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL toggle_b k=%0d got=%h want=%h", k, got, want);
      end
      if (if_a.o_frame_start) fs_a_cnt++;
      if (!if_b.o_VGA_VS && k >= 100 && k < 950) vs_low++;
      if (if_b.o_frame_start) begin
        n_checks++;
        if (prev_fs) begin
          n_fail++; $display("FAIL frame_start_width got=2+ want=1 at k=%0d", k);
        end
        if (last_fs >= 0) begin
          n_checks++;
          if (k - last_fs != 850) begin
            n_fail++; $display("FAIL frame_period_toggle got=%0d want=850", k - last_fs);
          end
        end
        last_fs = k;
      end
      prev_fs = if_b.o_frame_start;
    end
    n_checks++;
    if (fs_a_cnt != 1) begin
      n_fail++; $display("FAIL frame_start_a_count got=%0d want=1", fs_a_cnt);
    end
    // Two sync lines of 25 pixels, each pixel held for two clocks.
    n_checks++;
    if (vs_low != 100) begin
      n_fail++; $display("FAIL vs_width_toggle got=%0d want=100", vs_low);
    end
  endtask

  task automatic test_random_en();
    obs_t got, want;
    for (int k = 0; k < 2000; k++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'b1);
      got = obs_a(); want = exp_a(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL rand_a k=%0d got=%h want=%h", k, got, want);
      end
      got = obs_b(); want = exp_b(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL rand_b k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t got, want;
    int   guard;
    // First restart with "a" at (300,1), its sync pulse still pending.
    apply_reset();
    tick(1'b1, 1'b1);
    guard = 0;
    while (m != 1100 && guard < 3000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    n_checks++;
    if (if_a.o_x_cord !== 10'd300 || if_a.o_y_cord !== 10'd1) begin
      n_fail++; $display("FAIL mid_reset_point got=(%0d,%0d) want=(300,1)", if_a.o_x_cord, if_a.o_y_cord);
    end
    apply_reset();
    n_checks++;
    if (if_a.o_VGA_HS !== 1'b1 || if_a.o_VGA_VS !== 1'b1 || if_a.o_VGA_BLANK_N !== 1'b0 ||
        {if_a.o_VGA_R, if_a.o_VGA_G, if_a.o_VGA_B} !== 24'd0) begin
      n_fail++; $display("FAIL mid_reset_pins got hs=%b vs=%b bn=%b rgb=%h want 1 1 0 000000",
                         if_a.o_VGA_HS, if_a.o_VGA_VS, if_a.o_VGA_BLANK_N,
                         {if_a.o_VGA_R, if_a.o_VGA_G, if_a.o_VGA_B});
    end
    // Run until both instances drive HS low, then reset in the middle of the pulse.
    tick(1'b1, 1'b1);
    guard = 0;
    while (!(if_a.o_VGA_HS === 1'b0 && if_b.o_VGA_HS === 1'b0) && guard < 3000) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    n_checks++;
    if (guard >= 3000) begin
      n_fail++; $display("FAIL hs_low_wait got=timeout want=both low");
    end
    apply_reset();
    n_checks++;
    if (if_a.o_VGA_HS !== 1'b1 || if_b.o_VGA_HS !== 1'b1 || if_b.o_VGA_VS !== 1'b1 ||
        if_b.o_VGA_BLANK_N !== 1'b0) begin
      n_fail++; $display("FAIL hs_leak got a_hs=%b b_hs=%b b_vs=%b b_bn=%b want 1 1 1 0",
                         if_a.o_VGA_HS, if_b.o_VGA_HS, if_b.o_VGA_VS, if_b.o_VGA_BLANK_N);
    end
    for (int k = 0; k < 900; k++) begin
      tick(1'b1, 1'b1);
      if (k == 0) begin
        n_checks++;
        if (if_a.o_x_cord !== 10'd0 || if_a.o_y_cord !== 10'd0 || if_a.o_frame_start !== 1'b1) begin
          n_fail++; $display("FAIL restart got=(%0d,%0d) fs=%b want=(0,0) fs=1",
                             if_a.o_x_cord, if_a.o_y_cord, if_a.o_frame_start);
        end
      end
      got = obs_a(); want = exp_a(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL restart_a m=%0d got=%h want=%h", m, got, want);
      end
      got = obs_b(); want = exp_b(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL restart_b m=%0d got=%h want=%h", m, got, want);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line_timing();
    test_clk_en_toggle();
    test_random_en();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
